// File: rtl/prco_wb_arb_if.sv
// prco_wb_arb bus bundle: enable, ALU/load result inputs, and the
// registered write-port, stall/drop flags and pending-register mask.
// master: drives results (core side). slave: the arbiter.
interface prco_wb_arb_if;
   logic        i_en;
   logic        i_alu_valid;
   logic [2:0]  i_alu_rd;
   logic [15:0] i_alu_dat;
   logic        i_lsu_valid;
   logic [2:0]  i_lsu_rd;
   logic [15:0] i_lsu_dat;
   logic        q_lsu_ready;
   logic        q_alu_stall;
   logic        q_alu_drop;
   logic        q_we;
   logic [2:0]  q_seld;
   logic [15:0] q_datd;
   logic [7:0]  q_pend;

   modport master (
      output i_en, i_alu_valid, i_alu_rd, i_alu_dat,
      output i_lsu_valid, i_lsu_rd, i_lsu_dat,
      input  q_lsu_ready, q_alu_stall, q_alu_drop,
      input  q_we, q_seld, q_datd, q_pend
   );

   modport slave (
      input  i_en, i_alu_valid, i_alu_rd, i_alu_dat,
      input  i_lsu_valid, i_lsu_rd, i_lsu_dat,
      output q_lsu_ready, q_alu_stall, q_alu_drop,
      output q_we, q_seld, q_datd, q_pend
   );
endinterface

// File: rtl/prco_wb_arb.sv
// Register-file write-back arbiter: ALU results win the write slot,
// loads bypass when idle or queue in an in-order buffer.
// Ports: i_clk, i_reset (sync, active-high), bus (slave modport):
//   i_en, ALU/LSU result inputs, q_lsu_ready, q_alu_stall/drop,
//   q_we/q_seld/q_datd to prco_regs, q_pend hazard mask.
module prco_wb_arb #(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input logic          i_clk,
   input logic          i_reset,
   prco_wb_arb_if.slave bus
);
   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int AGW = $clog2(STARVE_MAX + 1);

   logic [DEPTH-1:0][2:0]  brd_q, brd_d;
   logic [DEPTH-1:0][15:0] bdat_q, bdat_d;
   logic [DEPTH-1:0]       vld_q, vld_d;
   logic [AW-1:0]          wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [AGW-1:0]         age_q, age_d;
   logic                   stall_q, stall_d;
   logic                   drop_q, drop_d;
   logic                   we_q, we_d;
   logic [2:0]             seld_q, seld_d;
   logic [15:0]            datd_q, datd_d;

   logic       empty, full, ready, acc;
   logic       pop, push, bypass;
   logic [7:0] pend;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CW'(DEPTH));
   assign ready = bus.i_en && !i_reset && !full;
   assign acc   = bus.i_lsu_valid && ready;

   always_comb begin
      brd_d   = brd_q;
      bdat_d  = bdat_q;
      vld_d   = vld_q;
      wp_d    = wp_q;
      rp_d    = rp_q;
      cnt_d   = cnt_q;
      age_d   = age_q;
      stall_d = stall_q;
      drop_d  = drop_q;
      we_d    = 1'b0;
      seld_d  = seld_q;
      datd_d  = datd_q;
      pop     = 1'b0;
      push    = 1'b0;
      bypass  = 1'b0;
      if (bus.i_en) begin
         stall_d = 1'b0;
         priority case (1'b1)
            stall_q && !empty: begin
               pop = 1'b1;
               if (bus.i_alu_valid) drop_d = 1'b1;
            end
            bus.i_alu_valid: begin
               we_d   = 1'b1;
               seld_d = bus.i_alu_rd;
               datd_d = bus.i_alu_dat;
            end
            !empty: pop = 1'b1;
            bus.i_lsu_valid: begin
               bypass = 1'b1;
               we_d   = 1'b1;
               seld_d = bus.i_lsu_rd;
               datd_d = bus.i_lsu_dat;
            end
            default: ;
         endcase
         if (pop) begin
            we_d        = 1'b1;
            seld_d      = brd_q[rp_q];
            datd_d      = bdat_q[rp_q];
            vld_d[rp_q] = 1'b0;
            rp_d        = rp_q + 1'b1;
         end
         // Push slot can't alias the pop slot: that needs full or empty.
         push = acc && !bypass;
         if (push) begin
            brd_d[wp_q]  = bus.i_lsu_rd;
            bdat_d[wp_q] = bus.i_lsu_dat;
            vld_d[wp_q]  = 1'b1;
            wp_d         = wp_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
         // Age of an unpopped head; on expiry, grant it one forced slot.
         if (pop || empty) begin
            age_d = '0;
         end else if (age_q == AGW'(STARVE_MAX - 1)) begin
            age_d   = '0;
            stall_d = 1'b1;
         end else begin
            age_d = age_q + 1'b1;
         end
      end
   end

   always_comb begin
      pend = '0;
      for (int i = 0; i < DEPTH; i++)
         if (vld_q[i]) pend[brd_q[i]] = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         brd_q   <= '0;
         bdat_q  <= '0;
         vld_q   <= '0;
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
         age_q   <= '0;
         stall_q <= 1'b0;
         drop_q  <= 1'b0;
         we_q    <= 1'b0;
         seld_q  <= '0;
         datd_q  <= '0;
      end else begin
         brd_q   <= brd_d;
         bdat_q  <= bdat_d;
         vld_q   <= vld_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         cnt_q   <= cnt_d;
         age_q   <= age_d;
         stall_q <= stall_d;
         drop_q  <= drop_d;
         we_q    <= we_d;
         seld_q  <= seld_d;
         datd_q  <= datd_d;
      end
   end

   assign bus.q_lsu_ready = ready;
   assign bus.q_alu_stall = stall_q;
   assign bus.q_alu_drop  = drop_q;
   assign bus.q_we        = we_q;
   assign bus.q_seld      = seld_q;
   assign bus.q_datd      = datd_q;
   assign bus.q_pend      = pend;
endmodule

// File: tb/tb_prco_wb_arb.sv
// Bench for prco_wb_arb: directed vector table plus hand sequences
// for reset, enable freeze and the sticky ALU drop flag.
module tb_prco_wb_arb;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;

   prco_wb_arb_if bus();

   prco_wb_arb #(.DEPTH(2), .STARVE_MAX(4)) dut (
      .i_clk  (clk),
      .i_reset(rst),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   logic [15:0] rf [8] = '{default: 16'h0};
   always @(posedge clk)
      if (bus.q_we) rf[bus.q_seld] <= bus.q_datd;

   typedef struct {
      logic        en;
      logic        av;
      logic [2:0]  ard;
      logic [15:0] adat;
      logic        lv;
      logic [2:0]  lrd;
      logic [15:0] ldat;
      logic        rdy;
      logic        we;
      logic [2:0]  seld;
      logic [15:0] datd;
      logic [7:0]  pend;
      logic        stall;
      logic        drop;
      logic [2:0]  rfi;
      logic [15:0] rfv;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(logic en, logic av, logic [2:0] ard,
                        logic [15:0] adat, logic lv,
                        logic [2:0] lrd, logic [15:0] ldat);
      bus.i_en        = en;
      bus.i_alu_valid = av;
      bus.i_alu_rd    = ard;
      bus.i_alu_dat   = adat;
      bus.i_lsu_valid = lv;
      bus.i_lsu_rd    = lrd;
      bus.i_lsu_dat   = ldat;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(string nm, logic we, logic [2:0] seld,
                          logic [15:0] datd, logic [7:0] pend,
                          logic stall, logic drop);
      chk({nm, ".we"}, 32'(bus.q_we), 32'(we));
      chk({nm, ".seld"}, 32'(bus.q_seld), 32'(seld));
      chk({nm, ".datd"}, 32'(bus.q_datd), 32'(datd));
      chk({nm, ".pend"}, 32'(bus.q_pend), 32'(pend));
      chk({nm, ".stall"}, 32'(bus.q_alu_stall), 32'(stall));
      chk({nm, ".drop"}, 32'(bus.q_alu_drop), 32'(drop));
   endtask

   task automatic add(logic en, logic av, logic [2:0] ard,
                      logic [15:0] adat, logic lv, logic [2:0] lrd,
                      logic [15:0] ldat, logic rdy, logic we,
                      logic [2:0] seld, logic [15:0] datd,
                      logic [7:0] pend, logic stall, logic drop,
                      logic [2:0] rfi, logic [15:0] rfv);
      vec_t v;
      v = '{en, av, ard, adat, lv, lrd, ldat, rdy, we, seld, datd,
            pend, stall, drop, rfi, rfv};
      vecs.push_back(v);
   endtask

   initial begin
      // en av ard adat  lv lrd ldat | rdy we seld datd pend st dr rfi rfv
      // bypass
      add(1,0,0,16'h0,   1,3,16'hF0F0, 1,1,3,16'hF0F0,8'h00,0,0,1,16'h1111);
      add(1,0,0,16'h0,   0,0,16'h0,    1,0,3,16'hF0F0,8'h00,0,0,3,16'hF0F0);
      // collision on r1
      add(1,1,1,16'h0001,1,1,16'hBEEF, 1,1,1,16'h0001,8'h02,0,0,3,16'hF0F0);
      add(1,0,0,16'h0,   0,0,16'h0,    1,1,1,16'hBEEF,8'h00,0,0,1,16'h0001);
      add(1,0,0,16'h0,   0,0,16'h0,    1,0,1,16'hBEEF,8'h00,0,0,1,16'hBEEF);
      // full buffer, then starvation slot
      add(1,1,7,16'h1000,1,2,16'h000A, 1,1,7,16'h1000,8'h04,0,0,1,16'hBEEF);
      add(1,1,7,16'h1001,1,4,16'h000B, 1,1,7,16'h1001,8'h14,0,0,7,16'h1000);
      add(1,1,7,16'h1002,1,5,16'h000C, 0,1,7,16'h1002,8'h14,0,0,7,16'h1001);
      add(1,1,7,16'h1003,1,5,16'h000C, 0,1,7,16'h1003,8'h14,0,0,7,16'h1002);
      add(1,1,7,16'h1004,1,5,16'h000C, 0,1,7,16'h1004,8'h14,1,0,7,16'h1003);
      add(1,0,0,16'h0,   1,5,16'h000C, 0,1,2,16'h000A,8'h10,0,0,7,16'h1004);
      add(1,1,7,16'h1005,1,5,16'h000C, 1,1,7,16'h1005,8'h30,0,0,2,16'h000A);
      add(1,0,0,16'h0,   0,0,16'h0,    0,1,4,16'h000B,8'h20,0,0,7,16'h1005);
      add(1,0,0,16'h0,   0,0,16'h0,    1,1,5,16'h000C,8'h00,0,0,4,16'h000B);
      add(1,0,0,16'h0,   0,0,16'h0,    1,0,5,16'h000C,8'h00,0,0,5,16'h000C);
      // one buffered load starved by a compliant ALU stream
      add(1,1,6,16'h2000,1,0,16'h00AA, 1,1,6,16'h2000,8'h01,0,0,5,16'h000C);
      add(1,1,6,16'h2001,0,0,16'h0,    1,1,6,16'h2001,8'h01,0,0,6,16'h2000);
      add(1,1,6,16'h2002,0,0,16'h0,    1,1,6,16'h2002,8'h01,0,0,6,16'h2001);
      add(1,1,6,16'h2003,0,0,16'h0,    1,1,6,16'h2003,8'h01,0,0,6,16'h2002);
      add(1,1,6,16'h2004,0,0,16'h0,    1,1,6,16'h2004,8'h01,1,0,6,16'h2003);
      add(1,0,0,16'h0,   0,0,16'h0,    1,1,0,16'h00AA,8'h00,0,0,6,16'h2004);
      add(1,1,6,16'h2005,0,0,16'h0,    1,1,6,16'h2005,8'h00,0,0,0,16'h00AA);
      add(1,0,0,16'h0,   0,0,16'h0,    1,0,6,16'h2005,8'h00,0,0,6,16'h2005);

      // reset, ALU issue, reset mid-stream with a buffered load
      rst = 1'b1;
      drive(1, 0, 0, 16'h0, 0, 0, 16'h0);
      tick();
      tick();
      chk("rst.ready", 32'(bus.q_lsu_ready), 32'd0);
      chk_out("rst", 0, 0, 16'h0, 8'h00, 0, 0);
      rst = 1'b0;
      drive(1, 1, 1, 16'h1111, 1, 6, 16'h6666);
      #1;
      chk("alu1.ready", 32'(bus.q_lsu_ready), 32'd1);
      tick();
      chk_out("alu1", 1, 1, 16'h1111, 8'h40, 0, 0);
      rst = 1'b1;
      drive(1, 0, 0, 16'h0, 0, 0, 16'h0);
      #1;
      chk("rst2.ready", 32'(bus.q_lsu_ready), 32'd0);
      tick();
      chk_out("rst2", 0, 0, 16'h0, 8'h00, 0, 0);
      rst = 1'b0;
      #1;
      chk("rel.ready", 32'(bus.q_lsu_ready), 32'd1);
      tick();
      chk_out("rel", 0, 0, 16'h0, 8'h00, 0, 0);

      foreach (vecs[k]) begin
         string nm;
         nm = $sformatf("v%0d", k);
         drive(vecs[k].en, vecs[k].av, vecs[k].ard, vecs[k].adat,
               vecs[k].lv, vecs[k].lrd, vecs[k].ldat);
         #1;
         chk({nm, ".ready"}, 32'(bus.q_lsu_ready), 32'(vecs[k].rdy));
         tick();
         chk_out(nm, vecs[k].we, vecs[k].seld, vecs[k].datd,
                 vecs[k].pend, vecs[k].stall, vecs[k].drop);
         chk({nm, ".rf"}, 32'(rf[vecs[k].rfi]), 32'(vecs[k].rfv));
      end

      // enable low freezes buffer and age counter
      drive(1, 1, 1, 16'h3000, 1, 2, 16'h0022);
      tick();
      chk_out("en.push", 1, 1, 16'h3000, 8'h04, 0, 0);
      for (int i = 0; i < 6; i++) begin
         drive(0, 1, 3, 16'h3333, 1, 4, 16'h4444);
         #1;
         chk("en0.ready", 32'(bus.q_lsu_ready), 32'd0);
         tick();
         chk_out("en0", 0, 1, 16'h3000, 8'h04, 0, 0);
      end
      drive(1, 0, 0, 16'h0, 0, 0, 16'h0);
      tick();
      chk_out("en.pop", 1, 2, 16'h0022, 8'h00, 0, 0);
      chk("en.rf3", 32'(rf[3]), 32'hF0F0);
      chk("en.rf4", 32'(rf[4]), 32'h000B);

      // ALU presenting during stall: dropped, flag sticky until reset
      drive(1, 1, 6, 16'h5000, 1, 1, 16'h0011);
      tick();
      for (int i = 1; i <= 4; i++) begin
         drive(1, 1, 6, 16'(16'h5000 + i), 0, 0, 16'h0);
         tick();
      end
      chk("drop.stall", 32'(bus.q_alu_stall), 32'd1);
      drive(1, 1, 7, 16'hDEAD, 0, 0, 16'h0);
      tick();
      chk_out("drop.hit", 1, 1, 16'h0011, 8'h00, 0, 1);
      drive(1, 1, 6, 16'h5005, 0, 0, 16'h0);
      tick();
      chk_out("drop.next", 1, 6, 16'h5005, 8'h00, 0, 1);
      drive(1, 0, 0, 16'h0, 0, 0, 16'h0);
      tick();
      tick();
      chk("drop.sticky", 32'(bus.q_alu_drop), 32'd1);
      chk("drop.rf7", 32'(rf[7]), 32'h1005);
      chk("drop.rf1", 32'(rf[1]), 32'h0011);
      drive(0, 0, 0, 16'h0, 0, 0, 16'h0);
      tick();
      chk("drop.en0", 32'(bus.q_alu_drop), 32'd1);
      rst = 1'b1;
      drive(1, 0, 0, 16'h0, 0, 0, 16'h0);
      tick();
      chk_out("drop.rst", 0, 0, 16'h0, 8'h00, 0, 0);
      rst = 1'b0;
      #1;
      chk("end.ready", 32'(bus.q_lsu_ready), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
